// File: rtl/prescaled_interval_timer.sv
// Interval timer: a mod-M prescaler clocks a W-bit countdown while running,
// emitting a registered one-cycle done_tick on expiry (one-shot or periodic).
module prescaled_interval_timer #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 100,
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [W-1:0] period,
   output logic         busy,
   output logic         pre_tick,
   output logic         done_tick,
   output logic [W-1:0] remaining
);

   localparam logic [N-1:0] PreMax = N'(M - 1);
   localparam logic [W-1:0] CntOne = W'(1);

   typedef enum logic {StIdle, StRun} state_t;

   state_t       state;
   logic [N-1:0] pre_reg;
   logic [W-1:0] cnt_reg;
   logic [W-1:0] per_reg;
   logic         mode_reg;
   logic         done_reg;

   assign busy      = (state == StRun);
   assign pre_tick  = (state == StRun) && (pre_reg == PreMax);
   assign done_tick = done_reg;
   assign remaining = cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= StIdle;
         pre_reg  <= '0;
         cnt_reg  <= '0;
         per_reg  <= '0;
         mode_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         unique case (state)
            StIdle: begin
               // stop outranks start even in IDLE, so a simultaneous pair does nothing
               if (start && !stop && (period != '0)) begin
                  state    <= StRun;
                  per_reg  <= period;
                  cnt_reg  <= period;
                  mode_reg <= periodic;
                  pre_reg  <= '0;
               end
            end
            StRun: begin
               if (stop || (start && (period == '0))) begin
                  state   <= StIdle;
                  cnt_reg <= '0;
                  pre_reg <= '0;
               end else if (start) begin
                  per_reg  <= period;
                  cnt_reg  <= period;
                  mode_reg <= periodic;
                  pre_reg  <= '0;
               end else begin
                  pre_reg <= pre_tick ? '0 : pre_reg + N'(1);
                  if (pre_tick) begin
                     if (cnt_reg > CntOne) begin
                        cnt_reg <= cnt_reg - CntOne;
                     end else begin
                        done_reg <= 1'b1;
                        if (mode_reg) begin
                           cnt_reg <= per_reg;
                        end else begin
                           cnt_reg <= '0;
                           state   <= StIdle;
                        end
                     end
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_prescaled_interval_timer.sv
// Directed bench: per-cycle vector table for M=4, hand sequences for periodic,
// reset and M=1 corner cases.
module tb_prescaled_interval_timer;

   typedef struct {
      logic       start;
      logic       stop;
      logic       periodic;
      logic [7:0] period;
      logic       busy;
      logic       pre;
      logic       done;
      logic [7:0] rem;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, periodic = 1'b0;
   logic [7:0] period = '0;
   logic       busy, pre_tick, done_tick;
   logic [7:0] remaining;
   logic       start1 = 1'b0, stop1 = 1'b0, periodic1 = 1'b0;
   logic [7:0] period1 = '0;
   logic       busy1, pre_tick1, done_tick1;
   logic [7:0] remaining1;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   prescaled_interval_timer #(.N(8), .M(4), .W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .periodic(periodic),
      .period(period), .busy(busy), .pre_tick(pre_tick), .done_tick(done_tick),
      .remaining(remaining)
   );

   prescaled_interval_timer #(.N(1), .M(1), .W(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1), .periodic(periodic1),
      .period(period1), .busy(busy1), .pre_tick(pre_tick1), .done_tick(done_tick1),
      .remaining(remaining1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic eb, input logic ep, input logic ed,
                          input logic [7:0] er);
      chk({name, ".busy"}, 32'(busy), 32'(eb));
      chk({name, ".pre_tick"}, 32'(pre_tick), 32'(ep));
      chk({name, ".done_tick"}, 32'(done_tick), 32'(ed));
      chk({name, ".remaining"}, 32'(remaining), 32'(er));
   endtask

   task automatic add(input logic st, input logic sp, input logic pm, input logic [7:0] per,
                      input logic eb, input logic ep, input logic ed, input logic [7:0] er);
      vec_t v;
      v.start = st; v.stop = sp; v.periodic = pm; v.period = per;
      v.busy = eb; v.pre = ep; v.done = ed; v.rem = er;
      vecs.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // One-shot, M=4, P=3: ticks in cycles 3,7,11, done in 12
      add(1, 0, 0, 3, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 3);
      add(0, 0, 0, 0, 1, 1, 0, 3);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 2);
      add(0, 0, 0, 0, 1, 1, 0, 2);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // period=0 ignored in IDLE
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // start+stop together while RUN
      add(1, 0, 0, 2, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 2);
      add(0, 0, 0, 0, 1, 1, 0, 2);
      add(1, 1, 0, 7, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // stop on the expiry tick
      add(1, 0, 0, 1, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // restart with period=5 on the expiry tick of a one-shot
      add(1, 0, 0, 1, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 1);
      add(1, 0, 0, 5, 1, 1, 0, 1);
      for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 0, 0, 5);
      add(0, 0, 0, 0, 1, 1, 0, 5);
      add(0, 1, 0, 0, 1, 0, 0, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // period=0 start in RUN acts as stop
      add(1, 0, 0, 2, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);

      #2;
      chk_out("reset_state", 0, 0, 0, 8'd0);
      chk("reset_state.m1_busy", 32'(busy1), 32'd0);
      #10 reset_n = 1'b1;
      next_cycle();

      foreach (vecs[i]) begin
         start = vecs[i].start; stop = vecs[i].stop;
         periodic = vecs[i].periodic; period = vecs[i].period;
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pre, vecs[i].done, vecs[i].rem);
         next_cycle();
      end
      start = 0; stop = 0; periodic = 0; period = 0;
      next_cycle();

      // Periodic, M=4, P=2: done every 8 cycles, no gap
      start = 1; periodic = 1; period = 2;
      next_cycle();
      start = 0; periodic = 0; period = 0;
      for (int c = 0; c <= 25; c++) begin
         @(negedge clk);
         chk_out($sformatf("per_c%0d", c), 1, (c % 4) == 3, (c > 0) && (c % 8 == 0),
                 ((c / 4) % 2 == 0) ? 8'd2 : 8'd1);
         next_cycle();
      end
      stop = 1;
      next_cycle();
      stop = 0;

      // Periodic again, stop at cycle 18
      start = 1; periodic = 1; period = 2;
      next_cycle();
      start = 0; periodic = 0; period = 0;
      for (int c = 0; c <= 30; c++) begin
         stop = (c == 18);
         @(negedge clk);
         if (c <= 18)
            chk_out($sformatf("perstop_c%0d", c), 1, (c % 4) == 3, (c > 0) && (c % 8 == 0),
                    ((c / 4) % 2 == 0) ? 8'd2 : 8'd1);
         else
            chk_out($sformatf("perstop_c%0d", c), 0, 0, 0, 8'd0);
         next_cycle();
      end
      stop = 0;

      // Asynchronous reset mid-run with remaining=3
      start = 1; period = 3;
      next_cycle();
      start = 0; period = 0;
      next_cycle();
      chk("rst_pre.remaining", 32'(remaining), 32'd3);
      chk("rst_pre.busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_out("rst_async", 0, 0, 0, 8'd0);
      @(negedge clk);
      reset_n = 1'b1;
      begin
         logic seen_done = 1'b0;
         logic seen_busy = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_done |= done_tick;
            seen_busy |= busy;
         end
         chk("rst_after.done_tick", 32'(seen_done), 32'd0);
         chk("rst_after.busy", 32'(seen_busy), 32'd0);
      end
      next_cycle();

      // M=1, P=1, periodic: tick every cycle, done every cycle from cycle 1
      start1 = 1; periodic1 = 1; period1 = 1;
      next_cycle();
      start1 = 0; periodic1 = 0; period1 = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("m1_c%0d.busy", c), 32'(busy1), 32'd1);
         chk($sformatf("m1_c%0d.pre_tick", c), 32'(pre_tick1), 32'd1);
         chk($sformatf("m1_c%0d.done_tick", c), 32'(done_tick1), (c >= 1) ? 32'd1 : 32'd0);
         chk($sformatf("m1_c%0d.remaining", c), 32'(remaining1), 32'd1);
         next_cycle();
      end
      stop1 = 1;
      next_cycle();
      stop1 = 0;
      @(negedge clk);
      chk("m1_stop.busy", 32'(busy1), 32'd0);
      chk("m1_stop.done_tick", 32'(done_tick1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prescaled_interval_timer.md
# prescaled_interval_timer

Programmable interval timer controller that sequences an internal mod-M prescaler and a W-bit countdown. It produces a single-cycle expiry pulse after a programmed number of prescaler ticks, in one-shot or periodic mode. It sits between control logic (UART baud generation, debounce, display refresh) and the free-running time base that such logic would otherwise build for itself. The prescaler runs only while a timer is active, so an idle timer consumes no counter activity.

## Interface
Parameters:
- N, 8: prescaler register width; N ≥ ceil(log2(M)), minimum 1.
- M, 100: prescaler modulus, M ≥ 1. The prescaler produces one tick per M clocks.
- W, 16: countdown and period width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle command: load `period`/`periodic` and begin timing.
- stop  input  1  single-cycle command: abort timing.
- periodic  input  1  mode select, sampled only when a start is accepted: 1 = auto-reload, 0 = one-shot.
- period  input  W  interval in prescaler ticks, sampled only when a start is accepted.
- busy  output  1  high while in RUN.
- pre_tick  output  1  combinational; high when prescaler = M-1 and state = RUN.
- done_tick  output  1  registered; one-cycle expiry pulse.
- remaining  output  W  current countdown value.

## Operation
- Registers:
  - state (IDLE/RUN)
  - pre_reg[N-1:0]
  - cnt_reg[W-1:0]
  - per_reg[W-1:0]
  - mode_reg
  - done_reg
- Reset (reset_n low, asynchronous): state = IDLE, pre_reg = 0, cnt_reg = 0, per_reg = 0, mode_reg = 0, done_reg = 0. Consequently busy = 0, pre_tick = 0, done_tick = 0, remaining = 0. Reset asserted mid-run aborts immediately, and no done_tick is produced.
- Command priority per cycle: stop > start > tick processing.
- IDLE:
  - start with period ≠ 0 → RUN. Load per_reg = period, cnt_reg = period, mode_reg = periodic, pre_reg = 0.
  - start with period = 0 is ignored: stay IDLE, all registers unchanged.
  - stop is ignored.
  - pre_reg holds at 0.
- RUN, prescaler: pre_reg = (pre_reg == M-1) ? 0 : pre_reg + 1.
- RUN, on a pre_tick cycle:
  - If cnt_reg > 1: cnt_reg decrements by 1.
  - If cnt_reg == 1 (expiry): done_reg = 1 at the edge.
    - If mode_reg = 1: cnt_reg = per_reg and stay in RUN.
    - If mode_reg = 0: cnt_reg = 0, state = IDLE.
- RUN + stop (with or without start): state = IDLE, cnt_reg = 0, pre_reg = 0. No done_tick, even if the same cycle was an expiry tick.
- RUN + start (no stop): restart. Reload per_reg, cnt_reg and mode_reg from the inputs and set pre_reg = 0. Any pending tick or expiry in that cycle is discarded. If the new period = 0, treat as stop.
- done_reg is cleared on every cycle that is not an expiry.
- Arithmetic: unsigned. cnt_reg never wraps below 0 because expiry is caught at 1. pre_reg compare is against M-1 truncated to N bits.

## Timing
- Start accepted at edge E0. At E0 busy rises and pre_reg = 0, so busy is high in the cycle after E0.
- pre_tick is high in cycles M-1, 2M-1, … counted from E0 (cycle 0 is the cycle after E0).
- With M = 1, pre_tick is high every RUN cycle.
- Expiry is at the edge ending cycle P·M-1. done_tick is high for exactly cycle P·M, so start-to-done latency is P·M clocks.
- One-shot: busy falls in the same cycle that done_tick is high.
- Periodic: done_tick repeats every P·M clocks with no gap cycle, and busy stays high.
- remaining updates on the edge that consumes each pre_tick.
- stop at edge Es: busy is low and remaining = 0 from the cycle after Es.

## Test plan
- Reset: M=4, W=8. Assert reset_n = 0 mid-RUN with remaining = 3 → all outputs 0 in the next sampled cycle (asynchronous). No done_tick after release.
- One-shot: M=4, period=3, periodic=0, start at E0 → pre_tick in cycles 3, 7, 11. remaining steps 3→2→1→0. done_tick high only in cycle 12, and busy low from cycle 12.
- Periodic: M=4, period=2, periodic=1 → done_tick in cycles 8, 16, 24. busy stays 1 and remaining reloads to 2 after each expiry. stop at cycle 18 → busy = 0 and remaining = 0 from cycle 19, with no further done_tick.
- Collisions:
  - start and stop in the same cycle while RUN → IDLE, no done_tick.
  - stop on the expiry tick cycle → no done_tick.
  - start (period=5) on the expiry tick of a one-shot → no done_tick, remaining = 5, busy = 1.
- period = 0 → start ignored in IDLE (busy stays 0). In RUN it acts as stop.
- M=1, period=1, periodic=1 → pre_tick every cycle and done_tick in every cycle from cycle 1 onward.
